// File: rtl/bnn_layer_scheduler.sv
// Sequences a chain of BNN layer engines over their level-based go/done handshake,
// with a per-layer watchdog, abort and a RUN-cycle counter.
module bnn_layer_scheduler #(
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int CNT_W          = 24,
  parameter int LW             = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] layer_done,
  output logic [NUM_LAYERS-1:0] layer_go,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ack,
  output logic                  error,
  output logic [LW-1:0]         error_layer,
  output logic [CNT_W-1:0]      cycle_count
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic          WDOG_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                r_state;
  logic [NUM_LAYERS-1:0] r_layer_go;
  logic                  r_busy;
  logic                  r_result_valid;
  logic                  r_error;
  logic [LW-1:0]         r_error_layer;
  logic [CNT_W-1:0]      r_cycle_count;
  logic [LW-1:0]         r_cur;
  logic [TW-1:0]         r_timer;

  logic                  w_cur_done;
  logic                  w_timeout;
  logic [CNT_W-1:0]      w_cnt_next;

  // Thermometer go pattern: every layer up to and including idx is enabled.
  function automatic logic [NUM_LAYERS-1:0] go_mask(input logic [LW-1:0] idx);
    logic [NUM_LAYERS-1:0] m;
    m = {NUM_LAYERS{1'b0}};
    for (int i = 0; i < NUM_LAYERS; i++) begin
      m[i] = (i <= int'(idx));
    end
    return m;
  endfunction

  assign w_cur_done = layer_done[r_cur];
  assign w_timeout  = WDOG_EN && (r_timer == TIMER_LAST);
  assign w_cnt_next = (r_cycle_count == {CNT_W{1'b1}}) ? r_cycle_count
                                                        : r_cycle_count + CNT_W'(1);

  // Scheduler FSM with all outputs registered; abort overrides every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_layer_go     <= {NUM_LAYERS{1'b0}};
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_error        <= 1'b0;
      r_error_layer  <= {LW{1'b0}};
      r_cycle_count  <= {CNT_W{1'b0}};
      r_cur          <= {LW{1'b0}};
      r_timer        <= {TW{1'b0}};
    end else if (abort) begin
      r_state        <= ST_IDLE;
      r_layer_go     <= {NUM_LAYERS{1'b0}};
      r_busy         <= 1'b0;
      r_result_valid <= 1'b0;
      r_cur          <= {LW{1'b0}};
      r_timer        <= {TW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Engines still showing done from the previous run must clear first.
          if (start && (layer_done == {NUM_LAYERS{1'b0}})) begin
            r_state       <= ST_RUN;
            r_layer_go    <= go_mask({LW{1'b0}});
            r_busy        <= 1'b1;
            r_cur         <= {LW{1'b0}};
            r_timer       <= {TW{1'b0}};
            r_cycle_count <= {CNT_W{1'b0}};
            r_error       <= 1'b0;
            r_error_layer <= {LW{1'b0}};
          end
        end
        ST_RUN: begin
          r_cycle_count <= w_cnt_next;
          r_timer       <= r_timer + TW'(1);
          if (w_cur_done) begin
            if (r_cur == LAST_LAYER) begin
              r_state        <= ST_HOLD;
              r_result_valid <= 1'b1;
            end else begin
              r_cur      <= r_cur + LW'(1);
              r_layer_go <= go_mask(r_cur + LW'(1));
              r_timer    <= {TW{1'b0}};
            end
          end else if (w_timeout) begin
            r_state       <= ST_IDLE;
            r_layer_go    <= {NUM_LAYERS{1'b0}};
            r_busy        <= 1'b0;
            r_error       <= 1'b1;
            r_error_layer <= r_cur;
            r_cur         <= {LW{1'b0}};
            r_timer       <= {TW{1'b0}};
          end
        end
        ST_HOLD: begin
          if (result_ack) begin
            r_state        <= ST_IDLE;
            r_layer_go     <= {NUM_LAYERS{1'b0}};
            r_busy         <= 1'b0;
            r_result_valid <= 1'b0;
            r_cur          <= {LW{1'b0}};
            r_timer        <= {TW{1'b0}};
          end
        end
        default: begin
          r_state        <= ST_IDLE;
          r_layer_go     <= {NUM_LAYERS{1'b0}};
          r_busy         <= 1'b0;
          r_result_valid <= 1'b0;
          r_cur          <= {LW{1'b0}};
          r_timer        <= {TW{1'b0}};
        end
      endcase
    end
  end

  assign layer_go     = r_layer_go;
  assign busy         = r_busy;
  assign result_valid = r_result_valid;
  assign error        = r_error;
  assign error_layer  = r_error_layer;
  assign cycle_count  = r_cycle_count;

endmodule

// File: tb/tb_bnn_layer_scheduler.sv
// Bench for bnn_layer_scheduler: model engines drive layer_done, a transaction-level
// reference model predicts every output each cycle; directed scenarios then random traffic.
module tb_bnn_layer_scheduler;

  localparam int NL  = 3;
  localparam int TMO = 16;
  localparam int CW  = 24;
  localparam int LWD = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start, abort, result_ack;
  logic [NL-1:0] layer_done;
  logic [NL-1:0] layer_go;
  logic          busy, result_valid, error;
  logic [LWD-1:0] error_layer;
  logic [CW-1:0] cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  logic drv_start, drv_abort, drv_ack;
  bit   rand_mode, abort_on_done1, abort_hit;
  int   lat[NL];
  int   stale_len;
  int   eng_cnt[NL];
  int   eng_hold[NL];
  logic [NL-1:0] eng_done;

  // reference model: 0 idle, 1 running, 2 holding result
  int m_st, m_cur, m_timer, m_cnt, m_err, m_errl;

  always #5 clk = ~clk;

  bnn_layer_scheduler #(
    .NUM_LAYERS(NL), .TIMEOUT_CYCLES(TMO), .CNT_W(CW), .LW(LWD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .layer_done(layer_done), .layer_go(layer_go), .busy(busy),
    .result_valid(result_valid), .result_ack(result_ack), .error(error),
    .error_layer(error_layer), .cycle_count(cycle_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cur = 0; m_timer = 0; m_cnt = 0; m_err = 0; m_errl = 0;
  endtask

  function automatic int exp_go();
    if (m_st == 0) return 0;
    else if (m_st == 2) return (1 << NL) - 1;
    else return (1 << (m_cur + 1)) - 1;
  endfunction

  task automatic model_next(input logic s, input logic a, input logic k, input logic [NL-1:0] d);
    if (a) m_st = 0;
    else if (m_st == 0) begin
      if (s && d == '0) begin
        m_st = 1; m_cur = 0; m_timer = 0; m_cnt = 0; m_err = 0; m_errl = 0;
      end
    end else if (m_st == 1) begin
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      if (d[m_cur]) begin
        if (m_cur == NL - 1) m_st = 2;
        else begin m_cur++; m_timer = 0; end
      end else if (m_timer == TMO - 1) begin
        m_st = 0; m_err = 1; m_errl = m_cur;
      end else m_timer++;
    end else if (k) m_st = 0;
  endtask

  task automatic check_outputs();
    chk("go",        32'(layer_go),     32'(exp_go()));
    chk("busy",      32'(busy),         32'(m_st != 0));
    chk("valid",     32'(result_valid), 32'(m_st == 2));
    chk("error",     32'(error),        32'(m_err));
    chk("err_layer", 32'(error_layer),  32'(m_errl));
    chk("cycles",    32'(cycle_count),  32'(m_cnt));
  endtask

  // engine: done rises lat cycles after go, lingers stale_len cycles after go drops
  task automatic engine_update();
    for (int i = 0; i < NL; i++) begin
      if (layer_go[i]) begin
        eng_cnt[i]++;
        if (eng_cnt[i] > lat[i]) eng_done[i] = 1'b1;
        eng_hold[i] = stale_len;
      end else if (eng_done[i] && eng_hold[i] > 0) eng_hold[i]--;
      else begin
        eng_done[i] = 1'b0;
        eng_cnt[i]  = 0;
      end
    end
  endtask

  task automatic step();
    logic [NL-1:0] noise;
    logic a_now;
    @(negedge clk);
    check_outputs();
    engine_update();
    noise = '0;
    if (rand_mode) begin
      drv_start = ($urandom_range(99) < 20);
      drv_abort = ($urandom_range(99) < 2);
      drv_ack   = ($urandom_range(99) < 25);
      for (int i = 0; i < NL; i++) noise[i] = ($urandom_range(99) < 4);
      if (m_st == 0 && drv_start) begin
        for (int i = 0; i < NL; i++) lat[i] = $urandom_range(18);
        stale_len = $urandom_range(2);
      end
    end
    a_now = drv_abort;
    if (abort_on_done1 && m_st == 1 && m_cur == 1 && eng_done[1]) begin
      a_now = 1'b1; abort_on_done1 = 1'b0; abort_hit = 1'b1;
    end
    start = drv_start; abort = a_now; result_ack = drv_ack;
    layer_done = eng_done | noise;
    model_next(start, abort, result_ack, layer_done);
  endtask

  task automatic run_until(input int st, input int budget, input string tag);
    int n;
    n = 0;
    do begin step(); n++; end while (m_st != st && n < budget);
    if (m_st != st) begin
      n_tests++; n_fail++;
      $display("FAIL %s: state %0d not reached within %0d cycles", tag, st, budget);
    end
  endtask

  task automatic set_lat(input int a, input int b, input int c);
    lat[0] = a; lat[1] = b; lat[2] = c;
  endtask

  task automatic pulse_start();
    drv_start = 1'b1; step(); drv_start = 1'b0;
  endtask

  task automatic finish_ack();
    drv_ack = 1'b1; step(); drv_ack = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; result_ack = 1'b0; layer_done = '0;
    drv_start = 1'b0; drv_abort = 1'b0; drv_ack = 1'b0;
    rand_mode = 1'b0; abort_on_done1 = 1'b0; abort_hit = 1'b0; stale_len = 0;
    eng_done = '0;
    for (int i = 0; i < NL; i++) begin eng_cnt[i] = 0; eng_hold[i] = 0; lat[i] = 4; end
    model_reset();
    #12;
    chk("rst_go",     32'(layer_go),     32'd0);
    chk("rst_busy",   32'(busy),         32'd0);
    chk("rst_valid",  32'(result_valid), 32'd0);
    chk("rst_error",  32'(error),        32'd0);
    chk("rst_cycles", 32'(cycle_count),  32'd0);
    #10 rst_n = 1'b1;

    // normal flow, engines 4 cycles each
    set_lat(4, 4, 4);
    step();
    pulse_start();
    run_until(2, 40, "normal_hold");
    step();
    chk("norm_cycles", 32'(cycle_count),  32'd15);
    chk("norm_go",     32'(layer_go),     32'd7);
    chk("norm_valid",  32'(result_valid), 32'd1);
    drv_ack = 1'b1; step(); drv_ack = 1'b0;
    step();
    chk("ack_go", 32'(layer_go), 32'd0);
    repeat (3) step();

    // watchdog on layer 1, then a fresh start clears error
    set_lat(3, 1000, 3);
    pulse_start();
    run_until(0, 60, "wdog_idle");
    step();
    chk("wdog_error", 32'(error),       32'd1);
    chk("wdog_layer", 32'(error_layer), 32'd1);
    chk("wdog_go",    32'(layer_go),    32'd0);
    chk("wdog_busy",  32'(busy),        32'd0);
    repeat (2) step();
    set_lat(3, 3, 3);
    pulse_start();
    run_until(2, 40, "wdog_rerun");
    step();
    chk("err_clear", 32'(error), 32'd0);
    finish_ack();

    // abort together with done[1]
    set_lat(2, 3, 3);
    abort_on_done1 = 1'b1; abort_hit = 1'b0;
    pulse_start();
    run_until(0, 40, "abort_idle");
    step();
    chk("abort_go",     32'(layer_go),     32'd0);
    chk("abort_valid",  32'(result_valid), 32'd0);
    chk("abort_error",  32'(error),        32'd0);
    chk("abort_cycles", 32'(cycle_count),  32'd6);
    abort_on_done1 = 1'b0;
    repeat (3) step();

    // stale done after ack with start held
    stale_len = 2;
    set_lat(2, 2, 2);
    pulse_start();
    run_until(2, 40, "stale_hold1");
    step();
    drv_ack = 1'b1; step(); drv_ack = 1'b0;
    drv_start = 1'b1;
    repeat (6) step();
    drv_start = 1'b0;
    run_until(2, 40, "stale_hold2");
    step();
    stale_len = 0;
    finish_ack();

    // done on last layer exactly at watchdog limit, then one cycle late
    set_lat(1, 1, 15);
    pulse_start();
    run_until(2, 60, "edge_hold");
    step();
    chk("edge_valid", 32'(result_valid), 32'd1);
    chk("edge_error", 32'(error),        32'd0);
    finish_ack();
    set_lat(1, 1, 16);
    pulse_start();
    run_until(0, 60, "late_idle");
    step();
    chk("late_error", 32'(error),       32'd1);
    chk("late_layer", 32'(error_layer), 32'd2);
    repeat (3) step();

    // async reset while holding
    set_lat(2, 2, 2);
    pulse_start();
    run_until(2, 40, "rst_hold");
    step();
    #1 rst_n = 1'b0;
    #1;
    chk("arst_go",     32'(layer_go),     32'd0);
    chk("arst_busy",   32'(busy),         32'd0);
    chk("arst_valid",  32'(result_valid), 32'd0);
    chk("arst_cycles", 32'(cycle_count),  32'd0);
    #1 rst_n = 1'b1;
    model_reset();
    repeat (2) step();
    pulse_start();
    run_until(2, 40, "post_rst_hold");
    step();
    chk("post_rst_cycles", 32'(cycle_count), 32'd9);
    finish_ack();

    // random traffic
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    drv_start = 1'b0; drv_abort = 1'b0; drv_ack = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bnn_layer_scheduler.md
Name: bnn_layer_scheduler

Overview:
Sequences the chain of BNN layer engines (conv/pool stages, then FC) over their level-based data_in_ready/data_out_ready protocol.
- An engine clears while its go is low, runs while go is high, and holds its result with done high.
- The scheduler raises each layer's go in order, keeps upstream go high so upstream outputs stay stable, and holds the whole chain until the result is consumed.
- It adds a per-layer watchdog, an abort input and a cycle counter. It sits between the image buffer/SPI control FSM and the layer engines.

Parameters:
NUM_LAYERS, 3, number of sequenced layer engines (>=1)
TIMEOUT_CYCLES, 65535, per-layer watchdog limit in cycles; 0 disables the watchdog
CNT_W, 24, width of the cycle counter
LW, $clog2(NUM_LAYERS) (min 1), width of the layer index

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request inference; sampled in IDLE only
abort  in  1  cancel operation; highest priority
layer_done  in  NUM_LAYERS  data_out_ready from each engine
layer_go  out  NUM_LAYERS  data_in_ready to each engine (thermometer code)
busy  out  1  high in RUN and HOLD
result_valid  out  1  last layer finished; outputs stable
result_ack  in  1  consumer has taken the result
error  out  1  sticky watchdog error
error_layer  out  LW  index of the layer that timed out
cycle_count  out  CNT_W  cycles spent in RUN for the current/last inference

Behaviour:
- Reset (async, rst_n low): state=IDLE; layer_go=0, busy=0, result_valid=0, error=0, error_layer=0, cycle_count=0, cur=0, timer=0. Reset asserted mid-run drops all go immediately and clears the engines.
- States: IDLE, RUN, HOLD. Registered outputs; every output change appears one cycle after the causing input edge.
- IDLE:
  - start=1 and layer_done==0 -> next: RUN, layer_go=...001, cur=0, timer=0, cycle_count=0, error=0, error_layer=0.
  - start with any layer_done bit high is ignored; the engines are still clearing stale done.
- RUN, each cycle:
  - cycle_count += 1, saturating at all-ones.
  - timer += 1.
  - If layer_done[cur]=1:
    - cur<NUM_LAYERS-1 -> cur+1, set layer_go[cur+1] (lower bits stay 1), timer=0.
    - cur==NUM_LAYERS-1 -> HOLD, result_valid=1, cycle_count frozen.
  - Else if TIMEOUT_CYCLES!=0 and timer==TIMEOUT_CYCLES-1 -> IDLE, layer_go=0, error=1, error_layer=cur.
- Only layer_done[cur] is evaluated. Done bits of other layers are ignored in RUN.
- HOLD: layer_go all ones, result_valid=1. result_ack=1 -> IDLE, layer_go=0, result_valid=0. cycle_count keeps its final value until the next accepted start.
- Priority within a cycle: abort > layer_done[cur] > timeout > result_ack/start.
  - done and timeout in the same cycle -> done wins.
  - abort in any state -> next cycle IDLE, layer_go=0, result_valid=0, busy=0. error and cycle_count are unchanged.
- start while busy is ignored, with no queueing. result_ack outside HOLD is ignored.
- NUM_LAYERS=1: the first done goes straight to HOLD.
- Minimum latency from start to result_valid: 1 + sum over layers of (engine latency + 1) cycles.

Test Plan:
- Normal flow (NUM_LAYERS=3, TIMEOUT=16): pulse start; model engines raise done 4 cycles after go.
  - layer_go must step 001->011->111.
  - result_valid=1 must appear 1 cycle after done[2].
  - cycle_count=15.
  - ack -> layer_go=000 next cycle.
- Watchdog: with done[1] never asserted, error=1, error_layer=1, layer_go=000 exactly 16 cycles after go[1] rose, busy=0. A new start clears error.
- Abort mid-RUN (cur=1), asserted together with done[1]: next cycle layer_go=000, IDLE, result_valid=0, error=0. cycle_count holds its value.
- Stale-done guard: start held while a model keeps done[0]=1 for 2 cycles after go drops. The first go must rise only after layer_done==0.
- Async reset in HOLD: drop rst_n between clock edges. All outputs are 0 immediately; start after release behaves normally.
- Ignored inputs: start pulses during RUN and result_ack during RUN have no effect. Done on a non-current layer is ignored. done[2]=1 with timer==TIMEOUT-1 -> HOLD, not error.
